// File: rtl/row_post_process_deskew.sv
// Skewed int32 systolic-array row -> fp16 (global or per-channel scale, optional ReLU),
// deskewed so each row leaves on one valid, with a per-tile row counter.
module row_post_process_deskew #(
    parameter int N_CH         = 32,
    parameter int IN_W         = 32,
    parameter int SCALE_LAT    = 3,
    parameter int SCALE_PER_CH = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH*IN_W-1:0] sys_array_out_32b,
    input  logic                 array_out_valid,
    input  logic [15:0]          global_scale_factor,
    input  logic [N_CH*16-1:0]   scale_vec,
    input  logic                 relu_en,
    input  logic [15:0]          tile_rows,
    output logic [N_CH*16-1:0]   fp16_out_aligned,
    output logic                 out_valid,
    output logic [15:0]          out_row_idx,
    output logic                 out_tile_last
);

    // Tag reaches the output register in the same cycle as the last lane's rounded result.
    localparam int TAG_D = N_CH + SCALE_LAT - 2;
    localparam int EXTRA = SCALE_LAT - 3;

    logic [1:0]          tag_q [TAG_D];
    logic [N_CH*16-1:0]  aligned_w;
    logic [N_CH*16-1:0]  row_d;
    logic [N_CH*16-1:0]  data_q;
    logic                valid_q;
    logic [15:0]         cnt_q;
    logic [15:0]         cnt_d;
    logic                tile_last_w;
    logic                unused_scale_w;

    assign unused_scale_w = ^{scale_vec, global_scale_factor};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < TAG_D; k++) tag_q[k] <= 2'b00;
        end else begin
            tag_q[0] <= {array_out_valid, relu_en};
            for (int k = 1; k < TAG_D; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_lane
            localparam int DEPTH = N_CH - 1 - gi;

            logic [31:0]        int_w;
            logic [15:0]        scale_w;
            logic [31:0]        mag_w;
            logic [4:0]         es_w;
            logic [10:0]        sig_w;
            logic [42:0]        prod_q;
            logic               sign1_q;
            logic [4:0]         es1_q;
            logic [5:0]         lead_w;
            logic [41:0]        norm_w;
            logic signed [7:0]  bexp_w;
            logic [9:0]         sub_w;
            logic               zero2_q;
            logic               sign2_q;
            logic               sub2_q;
            logic [9:0]         mant2_q;
            logic               grd2_q;
            logic               stk2_q;
            logic signed [7:0]  bexp2_q;
            logic [10:0]        rnd_w;
            logic signed [7:0]  bexpr_w;
            logic [15:0]        res_w;
            logic [15:0]        scaled_w;

            assign int_w   = sys_array_out_32b[gi*IN_W +: IN_W];
            assign scale_w = (SCALE_PER_CH != 0) ? scale_vec[gi*16 +: 16] : global_scale_factor;

            // Stage 1: |int| times fp16 significand; subnormal scales use exponent 1, no hidden bit.
            always_comb begin
                mag_w = int_w[31] ? -int_w : int_w;
                es_w  = (scale_w[14:10] == 5'd0) ? 5'd1 : scale_w[14:10];
                sig_w = {(scale_w[14:10] != 5'd0), scale_w[9:0]};
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prod_q  <= '0;
                    sign1_q <= 1'b0;
                    es1_q   <= '0;
                end else begin
                    prod_q  <= 43'(mag_w) * 43'(sig_w);
                    sign1_q <= int_w[31] ^ scale_w[15];
                    es1_q   <= es_w;
                end
            end

            // Stage 2: normalise. Value = prod * 2^(es-25); results below 2^-14 are exact
            // multiples of 2^-24, so the subnormal path never needs rounding.
            always_comb begin
                lead_w = '0;
                for (int k = 0; k < 43; k++) begin
                    if (prod_q[k]) lead_w = 6'(k);
                end
                norm_w = 42'(prod_q << (6'd42 - lead_w));
                bexp_w = $signed({2'b00, lead_w}) + $signed({3'b000, es1_q}) - 8'sd10;
                sub_w  = 10'(prod_q << (es1_q - 5'd1));
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    zero2_q <= 1'b0;
                    sign2_q <= 1'b0;
                    sub2_q  <= 1'b0;
                    mant2_q <= '0;
                    grd2_q  <= 1'b0;
                    stk2_q  <= 1'b0;
                    bexp2_q <= '0;
                end else begin
                    zero2_q <= (prod_q == 43'd0);
                    sign2_q <= sign1_q;
                    sub2_q  <= (bexp_w < 8'sd1);
                    mant2_q <= (bexp_w < 8'sd1) ? sub_w : norm_w[41:32];
                    grd2_q  <= (bexp_w >= 8'sd1) && norm_w[31];
                    stk2_q  <= (bexp_w >= 8'sd1) && (norm_w[30:0] != 31'd0);
                    bexp2_q <= bexp_w;
                end
            end

            // Stage 3 (combinational): round to nearest even, saturate to max finite.
            always_comb begin
                rnd_w   = {1'b0, mant2_q} + 11'(grd2_q & (stk2_q | mant2_q[0]));
                bexpr_w = bexp2_q + (rnd_w[10] ? 8'sd1 : 8'sd0);
                if (zero2_q) begin
                    res_w = {sign2_q, 15'd0};
                end else if (sub2_q) begin
                    res_w = {sign2_q, 5'd0, mant2_q};
                end else if (bexpr_w > 8'sd30) begin
                    res_w = {sign2_q, 15'h7BFF};
                end else begin
                    res_w = {sign2_q, bexpr_w[4:0], rnd_w[9:0]};
                end
            end

            if (EXTRA > 0) begin : g_extra
                logic [15:0] dly_q [EXTRA];
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        for (int k = 0; k < EXTRA; k++) dly_q[k] <= '0;
                    end else begin
                        dly_q[0] <= res_w;
                        for (int k = 1; k < EXTRA; k++) dly_q[k] <= dly_q[k-1];
                    end
                end
                assign scaled_w = dly_q[EXTRA-1];
            end else begin : g_no_extra
                assign scaled_w = res_w;
            end

            if (DEPTH == 0) begin : g_direct
                assign aligned_w[gi*16 +: 16] = scaled_w;
            end else begin : g_skew
                logic [15:0] skew_q [DEPTH];
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        for (int k = 0; k < DEPTH; k++) skew_q[k] <= '0;
                    end else begin
                        skew_q[0] <= scaled_w;
                        for (int k = 1; k < DEPTH; k++) skew_q[k] <= skew_q[k-1];
                    end
                end
                assign aligned_w[gi*16 +: 16] = skew_q[DEPTH-1];
            end
        end
    endgenerate

    always_comb begin
        row_d = aligned_w;
        for (int k = 0; k < N_CH; k++) begin
            if (tag_q[TAG_D-1][0] && aligned_w[k*16+15]) row_d[k*16 +: 16] = 16'h0000;
        end
        tile_last_w = valid_q && (tile_rows != 16'd0) && (cnt_q == 16'(tile_rows - 16'd1));
        cnt_d = cnt_q;
        if (valid_q) cnt_d = tile_last_w ? 16'd0 : 16'(cnt_q + 16'd1);
    end

    // Data register only loads on valid rows so the last row stays visible while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= tag_q[TAG_D-1][1];
            if (tag_q[TAG_D-1][1]) data_q <= row_d;
            cnt_q <= cnt_d;
        end
    end

    assign fp16_out_aligned = data_q;
    assign out_valid        = valid_q;
    assign out_row_idx      = cnt_q;
    assign out_tile_last    = tile_last_w;

endmodule

// File: tb/tb_row_post_process_deskew.sv
// Randomised bench: two instances (global / per-channel scale) checked every cycle
// against a real-arithmetic fp16 reference and a row-schedule model.
module tb_row_post_process_deskew;

    localparam int N       = 4;
    localparam int SL      = 3;
    localparam int LATENCY = SL + N - 1;
    localparam int NCYC    = 1800;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*32-1:0] din;
    logic            in_valid;
    logic            relu_en;
    logic [15:0]     gscale;
    logic [N*16-1:0] vscale;
    logic [15:0]     tile_rows;

    logic [N*16-1:0] dout_g, dout_v;
    logic            val_g, val_v;
    logic [15:0]     idx_g, idx_v;
    logic            last_g, last_v;

    always #5 clk = ~clk;

    row_post_process_deskew #(.N_CH(N), .IN_W(32), .SCALE_LAT(SL), .SCALE_PER_CH(0)) dut_g (
        .clk(clk), .rst_n(rst_n), .sys_array_out_32b(din), .array_out_valid(in_valid),
        .global_scale_factor(gscale), .scale_vec(vscale), .relu_en(relu_en), .tile_rows(tile_rows),
        .fp16_out_aligned(dout_g), .out_valid(val_g), .out_row_idx(idx_g), .out_tile_last(last_g));

    row_post_process_deskew #(.N_CH(N), .IN_W(32), .SCALE_LAT(SL), .SCALE_PER_CH(1)) dut_v (
        .clk(clk), .rst_n(rst_n), .sys_array_out_32b(din), .array_out_valid(in_valid),
        .global_scale_factor(gscale), .scale_vec(vscale), .relu_en(relu_en), .tile_rows(tile_rows),
        .fp16_out_aligned(dout_v), .out_valid(val_v), .out_row_idx(idx_v), .out_tile_last(last_v));

    bit          row_valid [NCYC];
    bit          row_relu  [NCYC];
    int          row_data  [NCYC][N];
    bit          rst_at    [NCYC];
    logic [15:0] gs_c      [NCYC];
    logic [15:0] vs_c      [NCYC][N];
    logic [15:0] tr_c      [NCYC];

    int n_checks = 0;
    int n_errors = 0;
    int cur_cyc  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cur_cyc, got, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int k = 0; k < e; k++) r = r * 2.0;
        else        for (int k = 0; k < -e; k++) r = r * 0.5;
        return r;
    endfunction

    // fp16 of v*s, round-to-nearest-even, magnitudes >= 65504 saturate to 0x7BFF.
    function automatic logic [15:0] fp16_ref(input int v, input logic [15:0] s);
        logic   sgn;
        longint mag;
        real    sv, p, f, fl, fr;
        int     e, q;
        sgn = (v < 0) ^ s[15];
        mag = (v < 0) ? -longint'(v) : longint'(v);
        if (s[14:10] == 5'd0) sv = real'(s[9:0]) * pow2(-24);
        else                  sv = real'({1'b1, s[9:0]}) * pow2(int'(s[14:10]) - 25);
        p = real'(mag) * sv;
        if (p == 0.0) return {sgn, 15'd0};
        if (p >= 65504.0) return {sgn, 15'h7BFF};
        if (p < pow2(-14)) begin
            q = int'(p * pow2(24));
            return {sgn, 5'd0, 10'(q)};
        end
        e = 15;
        while (p < pow2(e)) e--;
        f  = p / pow2(e - 10);
        fl = $floor(f);
        fr = f - fl;
        q  = int'(fl);
        if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
        if (q == 2048) begin q = 1024; e++; end
        return {sgn, 5'(e + 15), 10'(q - 1024)};
    endfunction

    function automatic int rand_int();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 40) - 20;
            1: return int'($urandom);
            2: case ($urandom_range(0, 4))
                   0: return 32'h7FFFFFFF;
                   1: return 32'h80000000;
                   2: return 0;
                   3: return 1;
                   default: return -1;
               endcase
            default: return $urandom_range(0, 140000) - 70000;
        endcase
    endfunction

    function automatic logic [15:0] rand_scale();
        logic [4:0] e;
        e = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 22));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    task automatic put_row(input int c, input int a0, input int a1, input int a2, input int a3,
                           input bit relu);
        row_valid[c]   = 1'b1;
        row_relu[c]    = relu;
        row_data[c][0] = a0;
        row_data[c][1] = a1;
        row_data[c][2] = a2;
        row_data[c][3] = a3;
    endtask

    task automatic build_schedule();
        logic [15:0] g, tr;
        logic [15:0] vv [N];
        for (int c = 0; c < NCYC; c++) begin
            row_valid[c] = 1'b0;
            row_relu[c]  = 1'b0;
            rst_at[c]    = 1'b0;
            gs_c[c]      = 16'h3C00;
            vs_c[c][0]   = 16'h3800;
            vs_c[c][1]   = 16'h3C00;
            vs_c[c][2]   = 16'h4000;
            vs_c[c][3]   = 16'h4400;
            tr_c[c]      = 16'd4;
        end
        rst_at[0] = 1'b1;
        rst_at[1] = 1'b1;
        put_row(3, 2, 2, 2, 2, 1'b0);
        put_row(20, 1, -3, 2, 0, 1'b1);
        put_row(21, 1, -3, 2, 0, 1'b0);
        put_row(22, 4, 4, 4, 4, 1'($urandom));
        put_row(23, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1);
        put_row(24, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b0);
        for (int c = 37; c < 40; c++) put_row(c, rand_int(), rand_int(), rand_int(), rand_int(), 1'($urandom));
        rst_at[40] = 1'b1;
        for (int c = 50; c < 60; c++) put_row(c, rand_int(), rand_int(), rand_int(), rand_int(), 1'($urandom));
        for (int s = 100; s + 150 <= NCYC - 20; s += 150) begin
            g  = rand_scale();
            for (int i = 0; i < N; i++) vv[i] = rand_scale();
            tr = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 1) == 1) rst_at[s] = 1'b1;
            for (int c = s; c < s + 150; c++) begin
                gs_c[c] = g;
                tr_c[c] = tr;
                for (int i = 0; i < N; i++) vs_c[c][i] = vv[i];
                if (c > s && c < s + 140 && $urandom_range(0, 9) < 7)
                    put_row(c, rand_int(), rand_int(), rand_int(), rand_int(), 1'($urandom));
                if (c > s && $urandom_range(0, 249) == 0) rst_at[c] = 1'b1;
            end
        end
    endtask

    task automatic drive(input int c);
        int src;
        rst_n     = !rst_at[c];
        in_valid  = row_valid[c];
        relu_en   = row_valid[c] ? row_relu[c] : 1'($urandom);
        gscale    = gs_c[c];
        tile_rows = tr_c[c];
        for (int i = 0; i < N; i++) begin
            vscale[i*16 +: 16] = vs_c[c][i];
            src = c - i;
            din[i*32 +: 32] = (src >= 0 && row_valid[src]) ? row_data[src][i] : $urandom;
        end
    endtask

    initial begin
        logic [15:0]     exp_idx;
        logic [15:0]     trm1;
        logic [N*16-1:0] exp_g, exp_v, hold_g, hold_v;
        logic [15:0]     lane;
        bit              ev, et;
        int              src;

        build_schedule();
        exp_idx = '0;
        hold_g  = '0;
        hold_v  = '0;
        drive(0);
        for (int c = 1; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cur_cyc = c;
            if (rst_at[c-1]) begin
                exp_idx = '0;
                hold_g  = '0;
                hold_v  = '0;
            end
            src = c - LATENCY;
            ev  = 1'b0;
            if (src >= 0 && row_valid[src]) begin
                ev = 1'b1;
                for (int k = src; k < c; k++) if (rst_at[k]) ev = 1'b0;
            end
            exp_g = hold_g;
            exp_v = hold_v;
            if (ev) begin
                for (int i = 0; i < N; i++) begin
                    lane = fp16_ref(row_data[src][i], gs_c[src]);
                    exp_g[i*16 +: 16] = (row_relu[src] && lane[15]) ? 16'h0000 : lane;
                    lane = fp16_ref(row_data[src][i], vs_c[src][i]);
                    exp_v[i*16 +: 16] = (row_relu[src] && lane[15]) ? 16'h0000 : lane;
                end
            end
            trm1 = tr_c[c] - 16'd1;
            et   = ev && (tr_c[c] != 16'd0) && (exp_idx == trm1);

            check_eq("valid_g", 64'(val_g), 64'(ev));
            check_eq("valid_v", 64'(val_v), 64'(ev));
            check_eq("row_idx_g", 64'(idx_g), 64'(exp_idx));
            check_eq("row_idx_v", 64'(idx_v), 64'(exp_idx));
            check_eq("tile_last_g", 64'(last_g), 64'(et));
            check_eq("tile_last_v", 64'(last_v), 64'(et));
            check_eq(ev ? "data_g" : "hold_g", 64'(dout_g), 64'(exp_g));
            check_eq(ev ? "data_v" : "hold_v", 64'(dout_v), 64'(exp_v));

            case (c)
                9:  check_eq("int2_scale1", 64'(dout_g), 64'h4000_4000_4000_4000);
                26: check_eq("relu_row", 64'(dout_g), {16'h0000, 16'h4000, 16'h0000, 16'h3C00});
                27: check_eq("norelu_row", 64'(dout_g), {16'h0000, 16'h4000, 16'hC200, 16'h3C00});
                28: check_eq("per_ch_scale", 64'(dout_v), {16'h4C00, 16'h4800, 16'h4400, 16'h4000});
                29: check_eq("sat_relu", 64'(dout_g), {16'h0000, 16'h7BFF, 16'h0000, 16'h7BFF});
                30: check_eq("sat_norelu", 64'(dout_g), {16'hFBFF, 16'h7BFF, 16'hFBFF, 16'h7BFF});
                41: check_eq("reset_idx", 64'(idx_g), 64'd0);
                default: ;
            endcase

            if (ev) begin
                $display("ROW cycle %0d idx %0d last %0d g %h v %h", c, idx_g, last_g, dout_g, dout_v);
                hold_g  = exp_g;
                hold_v  = exp_v;
                exp_idx = et ? 16'd0 : exp_idx + 16'd1;
            end
            drive(c);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
